// File: rtl/ps2_kbd_ascii_pkg.sv
// Shared definitions for the PS/2 keyboard to ASCII converter:
// Set-2 scan-code constants and the receiver state encoding.
package ps2_defs;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_e;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational Set-2 make-code to ASCII lookup. Letters follow shift XOR
// caps, digits/punctuation follow shift only, fixed keys ignore both.
module ps2_scan2ascii (
   input  logic [7:0] scan_i,
   input  logic       shift_i,
   input  logic       caps_i,
   output logic [7:0] ascii_o,
   output logic       valid_o
);

   logic       hit;
   logic       is_letter;
   logic [7:0] base;
   logic [7:0] shifted;

   // Table lookup: {hit, is_letter, unshifted, shifted}.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
      {hit, is_letter, base, shifted} = '0;
      unique case (scan_i)
         8'h1C: {hit, is_letter, base, shifted} = {2'b11, "a", "A"};
         8'h32: {hit, is_letter, base, shifted} = {2'b11, "b", "B"};
         8'h21: {hit, is_letter, base, shifted} = {2'b11, "c", "C"};
         8'h23: {hit, is_letter, base, shifted} = {2'b11, "d", "D"};
         8'h24: {hit, is_letter, base, shifted} = {2'b11, "e", "E"};
         8'h2B: {hit, is_letter, base, shifted} = {2'b11, "f", "F"};
         8'h34: {hit, is_letter, base, shifted} = {2'b11, "g", "G"};
         8'h33: {hit, is_letter, base, shifted} = {2'b11, "h", "H"};
         8'h43: {hit, is_letter, base, shifted} = {2'b11, "i", "I"};
         8'h3B: {hit, is_letter, base, shifted} = {2'b11, "j", "J"};
         8'h42: {hit, is_letter, base, shifted} = {2'b11, "k", "K"};
         8'h4B: {hit, is_letter, base, shifted} = {2'b11, "l", "L"};
         8'h3A: {hit, is_letter, base, shifted} = {2'b11, "m", "M"};
         8'h31: {hit, is_letter, base, shifted} = {2'b11, "n", "N"};
         8'h44: {hit, is_letter, base, shifted} = {2'b11, "o", "O"};
         8'h4D: {hit, is_letter, base, shifted} = {2'b11, "p", "P"};
         8'h15: {hit, is_letter, base, shifted} = {2'b11, "q", "Q"};
         8'h2D: {hit, is_letter, base, shifted} = {2'b11, "r", "R"};
         8'h1B: {hit, is_letter, base, shifted} = {2'b11, "s", "S"};
         8'h2C: {hit, is_letter, base, shifted} = {2'b11, "t", "T"};
         8'h3C: {hit, is_letter, base, shifted} = {2'b11, "u", "U"};
         8'h2A: {hit, is_letter, base, shifted} = {2'b11, "v", "V"};
         8'h1D: {hit, is_letter, base, shifted} = {2'b11, "w", "W"};
         8'h22: {hit, is_letter, base, shifted} = {2'b11, "x", "X"};
         8'h35: {hit, is_letter, base, shifted} = {2'b11, "y", "Y"};
         8'h1A: {hit, is_letter, base, shifted} = {2'b11, "z", "Z"};
         8'h16: {hit, is_letter, base, shifted} = {2'b10, "1", "!"};
         8'h1E: {hit, is_letter, base, shifted} = {2'b10, "2", "@"};
         8'h26: {hit, is_letter, base, shifted} = {2'b10, "3", "#"};
         8'h25: {hit, is_letter, base, shifted} = {2'b10, "4", "$"};
         8'h2E: {hit, is_letter, base, shifted} = {2'b10, "5", "%"};
         8'h36: {hit, is_letter, base, shifted} = {2'b10, "6", "^"};
         8'h3D: {hit, is_letter, base, shifted} = {2'b10, "7", "&"};
         8'h3E: {hit, is_letter, base, shifted} = {2'b10, "8", "*"};
         8'h46: {hit, is_letter, base, shifted} = {2'b10, "9", "("};
         8'h45: {hit, is_letter, base, shifted} = {2'b10, "0", ")"};
         8'h4E: {hit, is_letter, base, shifted} = {2'b10, "-", "_"};
         8'h55: {hit, is_letter, base, shifted} = {2'b10, "=", "+"};
         8'h54: {hit, is_letter, base, shifted} = {2'b10, "[", "{"};
         8'h5B: {hit, is_letter, base, shifted} = {2'b10, "]", "}"};
         8'h5D: {hit, is_letter, base, shifted} = {2'b10, "\\", "|"};
         8'h4C: {hit, is_letter, base, shifted} = {2'b10, ";", ":"};
         8'h52: {hit, is_letter, base, shifted} = {2'b10, "'", "\""};
         8'h41: {hit, is_letter, base, shifted} = {2'b10, ",", "<"};
         8'h49: {hit, is_letter, base, shifted} = {2'b10, ".", ">"};
         8'h4A: {hit, is_letter, base, shifted} = {2'b10, "/", "?"};
         8'h0E: {hit, is_letter, base, shifted} = {2'b10, 8'h60, "~"};
         8'h29: {hit, is_letter, base, shifted} = {2'b10, 8'h20, 8'h20};
         8'h5A: {hit, is_letter, base, shifted} = {2'b10, 8'h0D, 8'h0D};
         8'h66: {hit, is_letter, base, shifted} = {2'b10, 8'h08, 8'h08};
         8'h0D: {hit, is_letter, base, shifted} = {2'b10, 8'h09, 8'h09};
         8'h76: {hit, is_letter, base, shifted} = {2'b10, 8'h1B, 8'h1B};
         default: ;
      endcase
   end

   assign valid_o = hit;
   assign ascii_o = (is_letter ? (shift_i ^ caps_i) : shift_i) ? shifted : base;

endmodule

// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard receiver: pad conditioning, frame receiver with timeout,
// Set-2 decoder with modifier tracking, and an ASCII FIFO presented on the
// kbd_int / kbd_data / kbd_int_ack handshake.
module ps2_kbd_ascii
   import ps2_defs::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int TIMEOUT_US = 2000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk50M,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       kbd_int,
   output logic [7:0] kbd_data,
   input  logic       kbd_int_ack,
   output logic       kbd_overflow
);

   localparam int TO_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
   localparam int TW     = $clog2(TO_CYC + 1);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   // ---------------- input conditioning ----------------
   logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic       filt_q, strobe_q;
   logic [2:0] deb_cnt_q;

   // Two-flop synchronizers for both pad inputs (idle-high reset).
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let each flop take the previous stage's old value, forming a real shift chain.
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Debounce: filtered clock flips after 8 consecutive differing samples; a 1->0 flip strobes.
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         filt_q    <= 1'b1;
         deb_cnt_q <= '0;
         strobe_q  <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         if (clk_s2_q == filt_q) begin
            deb_cnt_q <= '0;
         end else if (deb_cnt_q == 3'd7) begin
            filt_q    <= clk_s2_q;
            deb_cnt_q <= '0;
            strobe_q  <= filt_q;
         end else begin
            deb_cnt_q <= deb_cnt_q + 3'd1;
         end
      end
   end

   // ---------------- frame receiver ----------------
   rx_state_e     state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_valid_q, byte_valid_d;
   logic [7:0]    code_q, code_d;

   // Receiver state register.
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         parity_q     <= 1'b0;
         to_cnt_q     <= '0;
         byte_valid_q <= 1'b0;
         code_q       <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         parity_q     <= parity_d;
         to_cnt_q     <= to_cnt_d;
         byte_valid_q <= byte_valid_d;
         code_q       <= code_d;
      end
   end

   // Receiver next state: advance on strobe, abandon the frame on inter-edge timeout.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      parity_d     = parity_q;
      byte_valid_d = 1'b0;
      code_d       = code_q;
      to_cnt_d     = (state_q == IDLE || strobe_q) ? '0 : to_cnt_q + 1'b1;

      if (strobe_q) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shreg_d   = {dat_s2_q, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_d = dat_s2_q;
               state_d  = STOP;
            end
            STOP: begin
               if (dat_s2_q && (^{shreg_q, parity_q})) begin
                  byte_valid_d = 1'b1;
                  code_d       = shreg_q;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && to_cnt_q == TW'(TO_CYC - 1)) begin
         state_d = IDLE;
      end
   end

   // ---------------- decoder ----------------
   logic       ext_q, brk_q, lshift_q, rshift_q, caps_q;
   logic [7:0] lut_ascii;
   logic       lut_valid;
   logic       push;
   logic       is_modifier;

   ps2_scan2ascii u_lut (
      .scan_i  (code_q),
      .shift_i (lshift_q | rshift_q),
      .caps_i  (caps_q),
      .ascii_o (lut_ascii),
      .valid_o (lut_valid)
   );

   assign is_modifier = (code_q == SC_EXT) || (code_q == SC_BRK) || (code_q == SC_LSHIFT) ||
                        (code_q == SC_RSHIFT) || (code_q == SC_CAPS);
   assign push = byte_valid_q && !ext_q && !brk_q && !is_modifier && lut_valid;

   // Prefix and modifier tracking; prefixes clear after the next ordinary code.
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         caps_q   <= 1'b0;
      end else if (byte_valid_q) begin
         if (code_q == SC_EXT) begin
            ext_q <= 1'b1;
         end else if (code_q == SC_BRK) begin
            brk_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            if (!ext_q) begin
               if (code_q == SC_LSHIFT)              lshift_q <= !brk_q;
               else if (code_q == SC_RSHIFT)         rshift_q <= !brk_q;
               else if (code_q == SC_CAPS && !brk_q) caps_q   <= !caps_q;
            end
         end
      end
   end

   // ---------------- FIFO and handshake ----------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          ack_prev_q, kbd_int_q, overflow_q;
   logic [7:0]    kbd_data_q;
   logic          pop, full, do_write;

   assign full     = (count_q == FULL_CNT);
   assign pop      = kbd_int_ack && !ack_prev_q && (count_q != '0);
   assign do_write = push && (!full || pop);

   // Storage array write port.
   always_ff @(posedge clk50M) begin
      // NOTE: storage is left unreset; count/pointers define validity, so clearing the array buys nothing.
      if (do_write) mem_q[wr_ptr_q] <= lut_ascii;
   end

   // Pointers, occupancy, registered head/interrupt and sticky overflow.
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ack_prev_q <= 1'b0;
         kbd_int_q  <= 1'b0;
         kbd_data_q <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         ack_prev_q <= kbd_int_ack;
         kbd_int_q  <= (count_q != '0);
         kbd_data_q <= mem_q[rd_ptr_q];
         if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_write && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !do_write) count_q <= count_q - 1'b1;
         if (push && full && !pop) overflow_q <= 1'b1;
      end
   end

   assign kbd_int      = kbd_int_q;
   assign kbd_data     = kbd_data_q;
   assign kbd_overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Directed bench for ps2_kbd_ascii: bit-bangs PS/2 frames and checks the
// ASCII handshake against hand-computed values.
module tb_ps2_kbd_ascii;

   localparam int H = 20;   // PS/2 half-bit period in system clocks

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk, ps2_data;
   logic       kbd_int, kbd_int_ack, kbd_overflow;
   logic [7:0] kbd_data;

   int n_vec = 0;
   int n_err = 0;

   ps2_kbd_ascii #(
      .CLK_FREQ   (1000000),
      .TIMEOUT_US (200),
      .FIFO_DEPTH (4)
   ) dut (
      .clk50M       (clk),
      .rst          (rst),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .kbd_int      (kbd_int),
      .kbd_data     (kbd_data),
      .kbd_int_ack  (kbd_int_ack),
      .kbd_overflow (kbd_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Sends the first nbits of a frame; optionally raises ack so that its
   // rising edge lands on the same clock as the resulting FIFO write
   // (2 sync + 8 debounce + strobe + byte_valid = write on 12th edge).
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit ack_at_write);
      logic [10:0] fr;
      fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = fr[i];
         repeat (H) @(negedge clk);
         ps2_clk = 1'b0;
         if (ack_at_write && i == 10) begin
            repeat (11) @(posedge clk);
            @(negedge clk);
            kbd_int_ack = 1'b1;
            repeat (H - 12) @(negedge clk);
         end else begin
            repeat (H) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (3 * H) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b0, 11, 1'b0);
   endtask

   // Waits (bounded) for kbd_int, checks the head, then pops it.
   task automatic pop_check(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      while (kbd_int !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, " int"}, {7'd0, kbd_int}, 8'h01);
      check(tag, kbd_data, exp);
      kbd_int_ack = 1'b1;
      repeat (2) @(negedge clk);
      kbd_int_ack = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst         = 1'b1;
      ps2_clk     = 1'b1;
      ps2_data    = 1'b1;
      kbd_int_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("reset int", {7'd0, kbd_int}, 8'h00);
      check("reset data", kbd_data, 8'h00);
      check("reset ovf", {7'd0, kbd_overflow}, 8'h00);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // single 'a'
      send(8'h1C);
      pop_check("t1 a", 8'h61);
      check("t1 int low", {7'd0, kbd_int}, 8'h00);

      // shift make/break; breaks produce nothing
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12); send(8'h1C);
      pop_check("t2 A", 8'h41);
      pop_check("t2 a", 8'h61);
      check("t2 empty", {7'd0, kbd_int}, 8'h00);

      // caps XOR shift on letters; caps does not affect digits
      send(8'h58); send(8'h12); send(8'h1C);
      send(8'hF0); send(8'h12); send(8'h16);
      pop_check("t3 caps+shift a", 8'h61);
      pop_check("t3 digit 1", 8'h31);
      check("t3 empty", {7'd0, kbd_int}, 8'h00);

      // bad parity, bad stop bit
      send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
      check("t4 bad parity", {7'd0, kbd_int}, 8'h00);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      check("t4 bad stop", {7'd0, kbd_int}, 8'h00);

      // partial frame abandoned by timeout, then a clean space
      send_frame(8'h29, 1'b0, 1'b0, 5, 1'b0);
      repeat (400) @(negedge clk);
      check("t5 partial no int", {7'd0, kbd_int}, 8'h00);
      send(8'h29);
      pop_check("t5 space", 8'h20);
      check("t5 single entry", {7'd0, kbd_int}, 8'h00);

      // reset clears caps; overflow and push+pop while full
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
      check("t6 ovf", {7'd0, kbd_overflow}, 8'h01);
      check("t6 int", {7'd0, kbd_int}, 8'h01);
      check("t6 head", kbd_data, 8'h61);
      send_frame(8'h2B, 1'b0, 1'b0, 11, 1'b1);
      kbd_int_ack = 1'b0;
      repeat (5) @(negedge clk);
      check("t6 ovf sticky", {7'd0, kbd_overflow}, 8'h01);
      pop_check("t6 b", 8'h62);
      pop_check("t6 c", 8'h63);
      pop_check("t6 d", 8'h64);
      pop_check("t6 f", 8'h66);
      check("t6 empty", {7'd0, kbd_int}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_ascii.md
Name: ps2_kbd_ascii

Overview:
- Upstream producer for the system's ASCII keyboard interface. Receives PS/2 keyboard frames, decodes Set-2 scan codes with modifier tracking, and converts them to ASCII.
- Buffers characters in a small FIFO and presents them on the kbd_int / kbd_data / kbd_int_ack handshake consumed by the memory/peripheral controller.
- Runs entirely in the clk50M domain.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside one frame before the frame is abandoned.
- FIFO_DEPTH, 4, ASCII buffer depth; must be a power of 2.

Ports:
- clk50M  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the pad; asynchronous.
- ps2_data  input  1  raw PS/2 data from the pad; asynchronous.
- kbd_int  output  1  high while the FIFO is non-empty.
- kbd_data  output  8  ASCII value at the FIFO head; valid while kbd_int=1.
- kbd_int_ack  input  1  consumer acknowledge; a rising edge pops one entry.
- kbd_overflow  output  1  sticky flag: a character was dropped because the FIFO was full.

Behaviour:
- Reset values: kbd_int=0, kbd_data=8'h00, kbd_overflow=0. FIFO empty, all modifier flags clear, receiver in IDLE.
- Input conditioning:
  - ps2_clk and ps2_data pass through 2-flop synchronizers.
  - ps2_clk is then debounced: the filtered level changes only after 8 consecutive equal samples.
  - A falling edge of the filtered clock produces a one-cycle sample strobe; ps2_data is sampled on that strobe.
- Receiver FSM (advances on the strobe only):
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE (bad start bit).
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: if stop bit=1 and the 9 bits (data + parity) have odd parity, emit a one-cycle byte_valid with the code. Otherwise discard silently. Always -> IDLE.
- Timeout: in any state other than IDLE, a counter counts cycles since the last strobe. At CLK_FREQ/1_000_000*TIMEOUT_US cycles, return to IDLE and discard the partial frame.
- Decoder (acts on byte_valid):
  - E0: set ext_pending.
  - F0: set brk_pending.
  - Any other code clears both flags after it is processed.
  - If ext_pending: no ASCII output, no modifier change.
  - 12 (L-shift) / 59 (R-shift): set the matching shift flag on make, clear it on break.
  - 58 (Caps Lock): toggle caps on make; ignore break.
  - Break codes of other keys: no output.
  - Make codes: look up ASCII.
    - Letters: uppercase when shift XOR caps is set.
    - Digits and punctuation: shifted variant when shift is set; caps has no effect.
    - Fixed codes: 29->20 (space), 5A->0D (enter), 66->08 (backspace), 0D->09 (tab), 76->1B (escape).
    - Unmapped codes produce nothing.
  - Latency from the strobe of the stop bit to the FIFO write is 2 cycles; kbd_int rises on the cycle after the write.
- FIFO and handshake:
  - Pop happens on a rising edge of kbd_int_ack (registered previous value) when the FIFO is non-empty. A pop while empty is ignored.
  - kbd_data is always the FIFO head and is registered. It updates one cycle after a pop or after a write into an empty FIFO.
  - Push while full and no pop in the same cycle: drop the character and set kbd_overflow.
  - Push and pop in the same cycle: both take effect; the count is unchanged, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH. The count width is log2(FIFO_DEPTH)+1.
- Reset asserted mid-frame or mid-handshake returns every state to reset values on the next clock edge after assertion (asynchronous clear).

Decomposition:
- Shared package ps2_defs:
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58.
  - Receiver state encoding: IDLE, DATA, PARITY, STOP.
- One sub-module: ps2_scan2ascii. Purely combinational: inputs scan code, shift and caps; outputs ascii[7:0] and a valid bit. Holds the lookup table.
- The FIFO stays inline.

Test Plan:
- Reset, then frame 1C (the 'a' key) with correct parity -> kbd_int=1 and kbd_data=61 within 12 cycles of the stop-bit strobe. Ack rising edge -> kbd_int=0.
- Sequence 12, 1C, F0, 1C, F0, 12, then 1C -> FIFO contents 41 then 61. Break codes produce no entries.
- Caps make 58, then 12, then 1C -> 61 (shift XOR caps). Then F0 12, then 16 -> 21 is not produced; the digit path yields 31.
- Frame 1C sent with bad parity, and separately a frame with stop bit 0 -> no FIFO write; kbd_int stays 0.
- Send 5 bits of a frame, then idle beyond the timeout, then a full 29 frame -> exactly one entry, value 20.
- Without acking, send 5 valid characters -> the FIFO holds the first 4 and kbd_overflow=1. Then push and ack in the same cycle while full -> count stays 4 and the head advances.
